// File: rtl/adap_quan_pkg.sv
// Shared ADPCM quantizer definitions: widths, RECONST log-magnitude table, pipeline stage records.
// Used by adap_dequan here and by the ADAP_QUAN quantizer tables.
package adap_quan_pkg;

    localparam int Y_W   = 13;
    localparam int DQ_W  = 16;
    localparam int DQL_W = 12;
    localparam int I_W   = 4;

    // RECONST output: log2 of the normalised quantized difference, indexed by |I|
    function automatic logic [DQL_W-1:0] dqlnLookup(input logic [2:0] im);
        logic [DQL_W-1:0] v;
        case (im)
            3'd0:    v = 12'd2048;
            3'd1:    v = 12'd4;
            3'd2:    v = 12'd135;
            3'd3:    v = 12'd213;
            3'd4:    v = 12'd273;
            3'd5:    v = 12'd323;
            3'd6:    v = 12'd373;
            default: v = 12'd425;
        endcase
        return v;
    endfunction

    typedef struct packed {
        logic             dqs;
        logic [DQL_W-1:0] dqln;
        logic [Y_W-3:0]   yShift;
    } stage1_t;

    typedef struct packed {
        logic             dqs;
        logic [DQL_W-1:0] dql;
    } stage2_t;

endpackage

// File: rtl/adap_antilog.sv
// Combinational ANTILOG: 12-bit log-domain DQL to 15-bit linear magnitude DQMAG.
module adap_antilog
    import adap_quan_pkg::*;
(
    input  logic [DQL_W-1:0] i_dql,
    output logic [DQ_W-2:0]  o_dqmag
);

    logic             w_ds;
    logic [3:0]       w_dex;
    logic [7:0]       w_dqt;
    logic [DQ_W-1:0]  w_shifted;

    assign w_ds  = i_dql[11];
    assign w_dex = i_dql[10:7];
    assign w_dqt = {1'b1, i_dql[6:0]};

    // Pre-scaling by one extra bit keeps every shift a right shift (DEX = 15 becomes a truncated left shift)
    assign w_shifted = {w_dqt, 8'b0} >> (4'd15 - w_dex);

    assign o_dqmag = w_ds ? '0 : w_shifted[DQ_W-2:0];

endmodule

// File: rtl/adap_dequan.sv
// Inverse adaptive quantizer: RECONST -> ADDA -> ANTILOG as a 3-stage valid/ready pipeline.
// Optional macro ADAP_DEQUAN_DQL_EN adds the dql_out port carrying stage-3 DQL alongside dq.
module adap_dequan
    import adap_quan_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_in0,
    input  logic             scan_en,
    output logic             scan_out0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [I_W-1:0]   i_code,
    input  logic [Y_W-1:0]   y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DQ_W-1:0]  dq
`ifdef ADAP_DEQUAN_DQL_EN
    ,
    output logic [DQL_W-1:0] dql_out
`endif
);

    logic             r_alive;
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    stage1_t          r_s1;
    stage2_t          r_s2;
    logic [DQ_W-1:0]  r_dq;
    logic             w_adv;
    logic             w_accept;
    logic [2:0]       w_im;
    logic [DQL_W-1:0] w_dql;
    logic [DQ_W-2:0]  w_dqmag;
    logic             w_unused;

    assign w_unused  = ^{scan_in0, scan_en, y[1:0]};
    assign scan_out0 = 1'b0;

    // Single global stall: every stage moves together whenever the output slot is free
    assign w_adv     = ~r_v3 | out_ready;
    assign in_ready  = w_adv & r_alive;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_v3;
    assign dq        = r_dq;

    assign w_im  = i_code[3] ? ~i_code[2:0] : i_code[2:0];
    assign w_dql = r_s1.dqln + {1'b0, r_s1.yShift};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Stage data only loads behind a valid, so bubbles leave the previous payload untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            if (w_adv && w_accept) begin
                r_s1.dqs    <= i_code[3];
                r_s1.dqln   <= dqlnLookup(w_im);
                r_s1.yShift <= y[Y_W-1:2];
            end
            if (w_adv && r_v1) begin
                r_s2.dqs <= r_s1.dqs;
                r_s2.dql <= w_dql;
            end
        end
    end

    adap_antilog u_antilog (
        .i_dql   (r_s2.dql),
        .o_dqmag (w_dqmag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dq <= '0;
        end else if (w_adv && r_v2) begin
            r_dq <= {r_s2.dqs, w_dqmag};
        end
    end

`ifdef ADAP_DEQUAN_DQL_EN
    logic [DQL_W-1:0] r_dql3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dql3 <= '0;
        end else if (w_adv && r_v2) begin
            r_dql3 <= r_s2.dql;
        end
    end

    assign dql_out = r_dql3;
`endif

endmodule

// File: tb/tb_adap_dequan.sv
// Scoreboard bench for adap_dequan; checks dql_out too when ADAP_DEQUAN_DQL_EN is defined.
module tb_adap_dequan;

    typedef struct {
        logic [15:0] dq;
        logic [11:0] dql;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in0;
    logic        scan_en;
    logic        scan_out0;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  i_code;
    logic [12:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dq;
`ifdef ADAP_DEQUAN_DQL_EN
    logic [11:0] dql_out;
`endif

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   popCount    = 0;
    exp_t scoreQ[$];

    always #5 clk = ~clk;

    adap_dequan dut (
        .clk       (clk),
        .reset     (reset),
        .scan_in0  (scan_in0),
        .scan_en   (scan_en),
        .scan_out0 (scan_out0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_code    (i_code),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dq        (dq)
`ifdef ADAP_DEQUAN_DQL_EN
        ,
        .dql_out   (dql_out)
`endif
    );

    // Reference computed straight from the RECONST/ADDA/ANTILOG arithmetic with plain integers
    function automatic exp_t modelDequan(input logic [3:0] code, input logic [12:0] yv);
        int   dqlnTab[8] = '{2048, 4, 135, 213, 273, 323, 373, 425};
        int   im;
        int   dql;
        int   dex;
        int   dqt;
        int   mag;
        exp_t r;
        im  = code[3] ? (7 - int'(code[2:0])) : int'(code[2:0]);
        dql = (dqlnTab[im] + int'(yv) / 4) % 4096;
        dex = (dql / 128) % 16;
        dqt = 128 + dql % 128;
        if (dql >= 2048)
            mag = 0;
        else if (dex <= 14)
            mag = (dqt * 128) >> (14 - dex);
        else
            mag = (dqt * 256) % 32768;
        r.dq  = {code[3], 15'(mag)};
        r.dql = 12'(dql);
        return r;
    endfunction

    // One clock of stimulus plus output scoring; a transfer is decided by the values held before the edge
    task automatic stepCycle(input logic v, input logic [3:0] c, input logic [12:0] yv,
                             input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        i_code    = c;
        y         = yv;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            testsRun++;
            popCount++;
            if (scoreQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_output dq=%h, none expected", dq);
            end else begin
                e = scoreQ.pop_front();
                if (dq !== e.dq) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard_dq got=%h expected=%h", dq, e.dq);
                end
`ifdef ADAP_DEQUAN_DQL_EN
                testsRun++;
                if (dql_out !== e.dql) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard_dql got=%h expected=%h", dql_out, e.dql);
                end
`endif
            end
        end
        acc = v && in_ready;
        if (acc) scoreQ.push_back(modelDequan(c, yv));
    endtask

    task automatic drain(input string name);
        logic acc;
        for (int i = 0; i < 12 && scoreQ.size() != 0; i++)
            stepCycle(1'b0, 4'd0, 13'd0, 1'b1, acc);
        testsRun++;
        if (scoreQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s_drain outstanding=%0d expected=0", name, scoreQ.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        i_code    = 4'd0;
        y         = 13'd0;
        out_ready = 1'b1;
        scan_in0  = 1'b0;
        scan_en   = 1'b0;
        #12;
        testsRun += 2;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid got=%b expected=0", out_valid);
        end
        if (dq !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_dq got=%h expected=0000", dq);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready got=%b expected=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  codes[6] = '{4'd4, 4'd12, 4'd0, 4'd15, 4'd7, 4'd8};
        logic [12:0] ys[6]    = '{13'd544, 13'd5120, 13'd5120, 13'd544, 13'd5120, 13'd544};
        logic [15:0] want[6]  = '{16'h0009, 16'h8D50, 16'h0000, 16'h8000, 16'h2A40, 16'h8016};
        logic        acc;
        int          lat;
        for (int k = 0; k < 6; k++) begin
            stepCycle(1'b1, codes[k], ys[k], 1'b1, acc);
            lat = 0;
            for (int i = 1; i <= 6 && lat == 0; i++) begin
                if (i > 1 || acc) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    #1;
                    if (out_valid) begin
                        lat = i;
                        testsRun++;
                        if (dq !== want[k]) begin
                            testsFailed++;
                            $display("[TB] FAIL directed_dq code=%0d y=%0d got=%h expected=%h",
                                     codes[k], ys[k], dq, want[k]);
                        end
                    end
                end
            end
            testsRun++;
            if (lat != 3) begin
                testsFailed++;
                $display("[TB] FAIL directed_latency code=%0d got=%0d expected=3", codes[k], lat);
            end
            scoreQ.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_bubbles();
        logic [3:0]  codes[4] = '{4'd1, 4'd7, 4'd13, 4'd6};
        logic [12:0] ys[4]    = '{13'd2000, 13'd8191, 13'd3000, 13'd4096};
        logic        acc;
        int          idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            if (c % 2 == 0) begin
                stepCycle(1'b1, codes[idx], ys[idx], 1'b1, acc);
                if (acc) idx++;
            end else begin
                stepCycle(1'b0, 4'hF, 13'h1FFF, 1'b1, acc);
            end
        end
        drain("bubbles");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  codes[6] = '{4'd2, 4'd11, 4'd5, 4'd14, 4'd3, 4'd9};
        logic [12:0] ys[6]    = '{13'd544, 13'd1200, 13'd2600, 13'd3900, 13'd5120, 13'd800};
        logic        acc;
        logic        ordy;
        int          idx = 0;
        int          startPops = popCount;
        int          stallSeen = 0;
        for (int c = 1; c <= 60 && !(idx == 6 && scoreQ.size() == 0); c++) begin
            ordy = !(c >= 4 && c <= 7);
            if (idx < 6) stepCycle(1'b1, codes[idx], ys[idx], ordy, acc);
            else         stepCycle(1'b0, 4'd0, 13'd0, ordy, acc);
            if (acc) idx++;
            if (out_valid && !out_ready) begin
                stallSeen++;
                testsRun += 2;
                if (in_ready !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_in_ready cycle=%0d got=%b expected=0", c, in_ready);
                end
                if (scoreQ.size() == 0 || dq !== scoreQ[0].dq) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_dq_hold cycle=%0d got=%h expected=%h", c, dq,
                             (scoreQ.size() == 0) ? 16'h0000 : scoreQ[0].dq);
                end
            end
        end
        testsRun += 2;
        if (popCount - startPops != 6) begin
            testsFailed++;
            $display("[TB] FAIL b2b_output_count got=%0d expected=6", popCount - startPops);
        end
        if (stallSeen == 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_stall_observed got=0 expected>0");
        end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        int   sawValid = 0;
        stepCycle(1'b1, 4'd7, 13'd5120, 1'b1, acc);
        stepCycle(1'b1, 4'd12, 13'd5120, 1'b1, acc);
        stepCycle(1'b0, 4'd0, 13'd0, 1'b1, acc);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_preload out_valid got=%b expected=1", out_valid);
        end
        reset = 1'b1;
        #1;
        testsRun += 2;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_out_valid got=%b expected=0", out_valid);
        end
        if (dq !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL midreset_dq got=%h expected=0000", dq);
        end
        scoreQ.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stepCycle(1'b0, 4'd0, 13'd0, 1'b1, acc);
            if (out_valid) sawValid++;
        end
        testsRun++;
        if (sawValid != 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_stale_output got=%0d expected=0", sawValid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_bubbles();
        test_back_to_back();
        test_reset_midstream();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/adap_dequan.md
Name: adap_dequan

Overview:
- Inverse adaptive quantizer for the mcac G.726 32 kbit/s ADPCM path; the counterpart of ADAP_QUAN.
- Takes 4-bit code I and quantizer scale factor Y. Outputs the reconstructed quantized difference DQ in 16-bit sign-magnitude form.
- Implements RECONST, ADDA and ANTILOG as a 3-stage valid/ready pipeline. Feeds the predictor/reconstruction logic on the decoder side and the local decoder of the encoder.

Parameters:
- Y_W, 13, scale-factor width (Y range 544..5120)
- DQ_W, 16, DQ width: bit 15 = sign, bits 14:0 = magnitude

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- scan_in0  input  1  scan chain in (DFT insertion only; no functional use)
- scan_en  input  1  scan enable (DFT insertion only)
- scan_out0  output  1  scan chain out (tied 0 pre-DFT)
- in_valid  input  1  I/Y pair valid
- in_ready  output  1  block accepts pair this cycle
- i_code  input  4  ADPCM code I
- y  input  13  scale factor Y
- out_valid  output  1  dq valid
- out_ready  input  1  downstream accepts dq
- dq  output  16  sign-magnitude DQ

Behaviour:
- Reset (asynchronous, active-high): all stage valids = 0; out_valid = 0; dq = 16'h0000; in_ready = 1 one cycle after reset deasserts.
- Handshake:
  - Global stall: adv = ~out_valid | out_ready; in_ready = adv.
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - Pipeline shifts only on adv; bubbles propagate as valid = 0.
  - Latency: 3 cycles accept-to-out_valid with no stall. Throughput: 1 per cycle.
  - dq holds stable while out_valid & ~out_ready.
- Stage 1, RECONST:
  - DQS = I[3]; IM = I[3] ? ~I[2:0] : I[2:0].
  - DQLN (12-bit) indexed by IM 0..7 = 2048, 4, 135, 213, 273, 323, 373, 425.
  - Register DQS, DQLN, and Y>>2 (11 bits).
- Stage 2, ADDA:
  - DQL = (DQLN + (Y>>2)) mod 4096, 12-bit wrap with carry discarded.
  - Register DQS and DQL.
- Stage 3, ANTILOG:
  - DS = DQL[11]; DEX = DQL[10:7]; DMN = DQL[6:0]; DQT = {1'b1, DMN} (8 bits).
  - DQMAG = DS ? 0 : ({DQT, 7'b0} >> (14 - DEX)), truncated to 15 bits.
  - dq = {DQS, DQMAG}. Negative zero (DQS = 1, DQMAG = 0) is legal and is output as-is.
- Boundaries:
  - IM = 0 always gives DQMAG = 0 for in-range Y.
  - Out-of-range Y (> 5120) is not checked; the mod-4096 arithmetic above still applies.
  - in_valid dropping mid-stream inserts a bubble only; no state is corrupted.
  - Reset mid-stream discards all in-flight samples; nothing is replayed.
  - Simultaneous accept and output in the same cycle is fully supported.

Optional Feature:
- Macro: ADAP_DEQUAN_DQL_EN.
- Defined: adds output port dql_out[11:0], the stage-3 DQL carried alongside dq. It is valid under the same out_valid/out_ready, and resets to 12'h000. Used for log-domain checking against the encoder.
- Undefined: port absent; DQL is not registered beyond stage 3 input; dq behaviour is identical.

Decomposition:
- Shared package adap_quan_pkg:
  - RECONST table constants (8 × 12-bit DQLN)
  - Y_W, DQ_W, DQL_W = 12, I_W = 4
  - Shared with ADAP_QUAN's quantizer tables.
- One sub-module, adap_antilog: combinational stage-3 DQL → DQMAG, reusable by the SR/antilog paths elsewhere in mcac.

Test Plan:
- Reset mid-stream: reset asserted with 2 samples in flight -> out_valid = 0 and dq = 0 immediately; no stale output after reset release.
- Basic: I = 4, Y = 544, out_ready = 1 -> 3 cycles later dq = 16'h0009 (DQL = 409).
- Sign and large scale: I = 12, Y = 5120 -> dq = 16'h8D50 (IM = 3, DQL = 1493, DQMAG = 3408).
- Zero/DS path: I = 0, Y = 5120 -> dq = 16'h0000. I = 15, Y = 544 -> dq = 16'h8000.
- Max magnitude: I = 7, Y = 5120 -> dq = 16'h2A40 (10816).
- Backpressure:
  - Stimulus: 6 back-to-back samples with out_ready low for cycles 4..7.
  - in_ready drops while out_valid & ~out_ready.
  - dq holds stable throughout the stall.
  - All 6 outputs arrive in order with none lost or duplicated.
  - With ADAP_DEQUAN_DQL_EN defined, dql_out matches the expected DQL for every output.
